ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite memory slave that consumes the bus signals carried by the team's AHB slave interface, acting as the DUT behind it. Decodes each address phase, stores/returns 32-bit data in an internal word-addressed array with byte-lane writes, inserts a programmable number of wait states, and returns the two-cycle ERROR response for illegal transfers.

## Interface
- MEM_DEPTH, 256: number of 32-bit words; legal byte addresses are 0 .. MEM_DEPTH*4-1.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted before each OKAY data phase completes (0..15).
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal.
- HWRITE  in  1  1 write, 0 read.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready from the response mux.
- HBURST  in  3  burst type; accepted, no effect on behaviour.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  00 OKAY, 01 ERROR; bit 1 always 0.
- HRDATA  out  32  read data.

## Operation
- Transfer accepted on a rising edge where HSEL=1, HREADY=1, HTRANS[1]=1. HADDR, HSIZE, HWRITE registered at that edge.
- Idle/BUSY/unselected address phase with HREADY=1: next cycle HREADYOUT=1, HRESP=00, no access.
- Illegal transfer, any of: HADDR >= MEM_DEPTH*4; HSIZE > 010; HSIZE=001 with HADDR[0]=1; HSIZE=010 with HADDR[1:0]!=0. Illegal transfers never touch memory.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=00. Legal accept -> WAIT if WAIT_STATES>0, else DATA. Illegal accept -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=00; down-counter loaded with WAIT_STATES-1 on entry; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=00; access completes at end of cycle. Legal accept -> WAIT/DATA, illegal accept -> ERR1, otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Accept follows DATA's rules.
- Write: in DATA, bytes of mem[addr>>2] written from HWDATA little-endian. Byte: lane addr[1:0]. Halfword: lanes {addr[1],0} and {addr[1],1}. Word: all four lanes. Commit on the edge ending DATA.
- Read: in DATA, HRDATA = full word mem[addr>>2], regardless of HSIZE. HRDATA = 0 in all other states.
- Write to word A followed by an immediate read of A returns the new data, because the write commits before the read's DATA cycle.

## Timing
- Reset (HRESETn=0, asynchronous): state IDLE, counter 0, HREADYOUT=1, HRESP=00, HRDATA=0. Memory contents are not reset.
- Reset mid-transfer aborts the transfer; a write in WAIT or DATA at reset assertion is not committed.
- Zero-wait latency: address phase sampled at edge N; data phase is cycle N..N+1 with HREADYOUT=1. Read data is valid before edge N+1. Write commits at edge N+1.
- WAIT_STATES=k: HREADYOUT=0 for exactly k cycles, then 1 for one cycle.
- ERROR response is always exactly 2 cycles: HREADYOUT 0 then 1, HRESP=01 in both.
- While HREADY=0, address-phase inputs are ignored; no accept occurs.
- Pipelined back-to-back transfers sustain one transfer per cycle when WAIT_STATES=0.

## Test plan
- Reset then idle: HRESETn low mid-cycle -> HREADYOUT=1, HRESP=00, HRDATA=0 immediately. HTRANS=IDLE for 5 cycles -> no change.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF in the read data phase, HRESP=00 throughout.
- Byte/halfword lanes: word 0x11223344 at 0x20; byte write 0xAA to 0x22; halfword write 0xBBCC to 0x20 -> word read returns 0x11AABBCC.
- Errors: word access at 0x02, HSIZE=011, and HADDR=MEM_DEPTH*4 -> each gives HREADYOUT 0,1 with HRESP=01 for 2 cycles. A following read shows memory unchanged.
- Wait states: WAIT_STATES=3, read 0x0 -> HREADYOUT low for exactly 3 cycles, then high with valid HRDATA.
- Reset during WAIT of a write to 0x30 (old value 0x12345678) -> after reset, read of 0x30 returns 0x12345678.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte lanes, programmable wait states and two-cycle ERROR response
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  input  logic [2:0]  hburst,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, nxt, go;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] a_idx;
  logic [1:0] a_lo, a_size;
  logic a_write, acc_ok, take, legal, unused_ok;
  logic [3:0] be;
  logic [31:0] mem [MEM_DEPTH];
  assign unused_ok = ^{hburst, htrans[0]};
  assign acc_ok = state == S_IDLE || state == S_DATA || state == S_ERR2;
  assign take = hsel && hready && htrans[1] && acc_ok;
  assign legal = haddr < 32'(MEM_DEPTH * 4) && hsize <= 3'd2 &&
                 !(hsize == 3'd1 && haddr[0]) && !(hsize == 3'd2 && haddr[1:0] != 2'd0);
  assign go = !take ? S_IDLE : !legal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
  for (genvar l = 0; l < 4; l++) begin : g_be
    localparam logic [1:0] LN = 2'(l);
    assign be[l] = a_size == 2'd2 || (a_size == 2'd1 && a_lo[1] == LN[1]) || (a_size == 2'd0 && a_lo == LN);
  end
  // next state, wait counter and bus response for the current data phase
  always_comb begin
    hreadyout = acc_ok;
    hresp = {1'b0, state == S_ERR1 || state == S_ERR2};
    nxt = state == S_WAIT ? (cnt == 4'd0 ? S_DATA : S_WAIT) : state == S_ERR1 ? S_ERR2 : go;
    cnt_n = state == S_WAIT ? (cnt == 4'd0 ? 4'd0 : cnt - 4'd1) : go == S_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
    hrdata = state == S_DATA && !a_write ? mem[a_idx] : 32'd0;
  end
  // state register and captured address phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      a_idx <= '0;
      a_lo <= 2'd0;
      a_size <= 2'd0;
      a_write <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      if (take) begin
        a_idx <= haddr[AW+1:2];
        a_lo <= haddr[1:0];
        a_size <= hsize[1:0];
        a_write <= hwrite;
      end
    end
  end
  // write commits on the edge that ends the data phase; contents survive reset
  always_ff @(posedge hclk) begin
    if (state == S_DATA && a_write)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_idx][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized and directed checks of two slaves (0 and 3 wait states) against a byte-array model
module tb_ahb_sram_slave;
  logic hclk = 1'b0;
  logic hresetn = 1'b1;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [2:0]  hburst [2];
  logic        hro    [2];
  logic [1:0]  hresp  [2];
  logic [31:0] hrdata [2];
  logic [7:0]  bmem [2][1024];
  int checks = 0;
  int errors = 0;
  logic [31:0] rd, a, m0;
  logic [2:0] sz;
  int pick;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hsize(hsize[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]), .hready(hro[0]), .hburst(hburst[0]),
    .hreadyout(hro[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hsize(hsize[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]), .hready(hro[1]), .hburst(hburst[1]),
    .hreadyout(hro[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int d, input logic [31:0] ad);
    int w = int'(ad) & ~3;
    return {bmem[d][w+3], bmem[d][w+2], bmem[d][w+1], bmem[d][w]};
  endfunction

  function automatic logic is_legal(input logic [31:0] ad, input logic [2:0] s);
    return ad < 32'd1024 && s <= 3'd2 && ad % (32'd1 << s) == 32'd0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        chk("idle_rdy", 32'(hro[d]), 32'd1);
        chk("idle_resp", 32'(hresp[d]), 32'd0);
        chk("idle_rdata", hrdata[d], 32'd0);
        hsel[d] = 1'($urandom_range(0, 1));
        htrans[d] = 2'($urandom_range(0, 1));
        haddr[d] = $urandom;
      end
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] ad, input logic [2:0] s, input logic wr,
                      input logic [31:0] wd, output logic [31:0] r);
    int ws;
    logic ok;
    logic [31:0] exp;
    ws = d == 1 ? 3 : 0;
    ok = is_legal(ad, s);
    exp = ok && !wr ? mword(d, ad) : 32'd0;
    hsel[d] = 1'b1;
    haddr[d] = ad;
    htrans[d] = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    hsize[d] = s;
    hwrite[d] = wr;
    hburst[d] = 3'($urandom_range(0, 7));
    chk("addr_rdy", 32'(hro[d]), 32'd1);
    @(posedge hclk);
    #1;
    hsel[d] = 1'($urandom_range(0, 1));
    htrans[d] = 2'b00;
    haddr[d] = $urandom;
    hsize[d] = 3'($urandom_range(0, 7));
    hwrite[d] = 1'($urandom_range(0, 1));
    hwdata[d] = wd;
    if (ok) begin
      for (int i = 0; i < ws; i++) begin
        @(negedge hclk);
        chk("wait_rdy", 32'(hro[d]), 32'd0);
        chk("wait_resp", 32'(hresp[d]), 32'd0);
        chk("wait_rdata", hrdata[d], 32'd0);
      end
      @(negedge hclk);
      chk("data_rdy", 32'(hro[d]), 32'd1);
      chk("data_resp", 32'(hresp[d]), 32'd0);
      chk(wr ? "wr_rdata" : "rd_data", hrdata[d], exp);
      r = hrdata[d];
      if (wr)
        for (int k = 0; k < (1 << s); k++)
          bmem[d][int'(ad) + k] = wd[8*((int'(ad) + k) % 4) +: 8];
    end else begin
      @(negedge hclk);
      chk("err1_rdy", 32'(hro[d]), 32'd0);
      chk("err1_resp", 32'(hresp[d]), 32'd1);
      chk("err1_rdata", hrdata[d], 32'd0);
      @(negedge hclk);
      chk("err2_rdy", 32'(hro[d]), 32'd1);
      chk("err2_resp", 32'(hresp[d]), 32'd1);
      chk("err2_rdata", hrdata[d], 32'd0);
      r = hrdata[d];
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hsize[d] = 3'd0;
      hwrite[d] = 1'b0; hwdata[d] = '0; hburst[d] = 3'd0;
    end
    #3 hresetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(hro[d]), 32'd1);
      chk("rst_resp", 32'(hresp[d]), 32'd0);
      chk("rst_rdata", hrdata[d], 32'd0);
    end
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    idle(5);
    for (int w = 0; w < 16; w++) xfer(0, 32'(w * 4), 3'd2, 1'b1, $urandom, rd);
    xfer(0, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, rd);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, rd);
    chk("b2b_read", rd, 32'hDEADBEEF);
    xfer(0, 32'h20, 3'd2, 1'b1, 32'h11223344, rd);
    xfer(0, 32'h22, 3'd0, 1'b1, 32'h00AA0000, rd);
    xfer(0, 32'h20, 3'd1, 1'b1, 32'h0000BBCC, rd);
    xfer(0, 32'h20, 3'd2, 1'b0, 32'h0, rd);
    chk("lanes", rd, 32'h11AABBCC);
    m0 = mword(0, 32'h0);
    xfer(0, 32'h02, 3'd2, 1'b1, 32'hFFFFFFFF, rd);
    xfer(0, 32'h10, 3'd3, 1'b1, 32'hFFFFFFFF, rd);
    xfer(0, 32'd1024, 3'd2, 1'b1, 32'hFFFFFFFF, rd);
    xfer(0, 32'h21, 3'd1, 1'b1, 32'hFFFFFFFF, rd);
    xfer(0, 32'h00, 3'd2, 1'b0, 32'h0, rd);
    chk("err_keep0", rd, m0);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, rd);
    chk("err_keep10", rd, 32'hDEADBEEF);
    xfer(0, 32'h20, 3'd2, 1'b0, 32'h0, rd);
    chk("err_keep20", rd, 32'h11AABBCC);
    repeat (300) begin
      sz = 3'($urandom_range(0, 2));
      a = $urandom_range(0, 63);
      pick = $urandom_range(0, 19);
      if (pick == 0) sz = 3'($urandom_range(3, 7));
      else if (pick == 1) a = 32'd1024 + $urandom_range(0, 4095);
      else if (pick > 3) a = a - (a % (32'd1 << sz));
      xfer(0, a, sz, 1'($urandom_range(0, 1)), $urandom, rd);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    xfer(1, 32'h0, 3'd2, 1'b1, 32'h5A5A1234, rd);
    xfer(1, 32'h0, 3'd2, 1'b0, 32'h0, rd);
    chk("ws_read", rd, 32'h5A5A1234);
    xfer(1, 32'h30, 3'd2, 1'b1, 32'h12345678, rd);
    idle(1);
    hsel[1] = 1'b1; haddr[1] = 32'h30; htrans[1] = 2'b10; hsize[1] = 3'd2; hwrite[1] = 1'b1;
    @(posedge hclk);
    #1;
    htrans[1] = 2'b00;
    hwdata[1] = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("abort_wait_rdy", 32'(hro[1]), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("abort_rst_rdy", 32'(hro[1]), 32'd1);
    chk("abort_rst_resp", 32'(hresp[1]), 32'd0);
    chk("abort_rst_rdata", hrdata[1], 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    xfer(1, 32'h30, 3'd2, 1'b0, 32'h0, rd);
    chk("abort_keep30", rd, 32'h12345678);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
